// File: rtl/imm_decode_ctrl.sv
// imm_decode_ctrl: decode-stage sequencer that owns the ID/EX immediate register.
// Optional macro IMM_SYS_DECODE_EN decodes FENCE/SYSTEM as I-type. Rev 1.0
`default_nettype none

module imm_decode_ctrl #(
  parameter int unsigned LOAD_BUBBLES = 1,
  parameter logic [2:0]  ILLEGAL_SEL  = 3'b111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic [2:0]  ins_type_sel,
  input  logic [31:0] imm_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [2:0]  out_type,
  output logic        out_illegal
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
`ifdef IMM_SYS_DECODE_EN
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
`endif

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_instr_q, out_instr_d;
  logic [31:0] out_pc_q, out_pc_d;
  logic [31:0] out_imm_q, out_imm_d;
  logic [2:0]  out_type_q, out_type_d;
  logic        out_illegal_q, out_illegal_d;

  logic        illegal;
  logic        use_rs1;
  logic        use_rs2;
  logic        hazard;
  logic        capture;
  logic [4:0]  load_rd;

  always_comb begin
    ins_type_sel = ILLEGAL_SEL;
    illegal      = 1'b0;
    use_rs1      = 1'b0;
    use_rs2      = 1'b0;
    case (in_instr[6:0])
      OPC_LOAD, OPC_OPIMM, OPC_JALR: begin
        ins_type_sel = 3'd0;
        use_rs1      = 1'b1;
      end
      OPC_STORE: begin
        ins_type_sel = 3'd1;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OPC_BRANCH: begin
        ins_type_sel = 3'd2;
        use_rs1      = 1'b1;
        use_rs2      = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: ins_type_sel = 3'd3;
      OPC_JAL:            ins_type_sel = 3'd4;
      OPC_OP: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
`ifdef IMM_SYS_DECODE_EN
      OPC_FENCE, OPC_SYSTEM: begin
        ins_type_sel = 3'd0;
        use_rs1      = 1'b1;
      end
`endif
      default: illegal = 1'b1;
    endcase
  end

  // A load with rd=x0 writes nothing, so it can never create a hazard.
  assign load_rd = out_instr_q[11:7];
  assign hazard  = out_valid_q && (out_instr_q[6:0] == OPC_LOAD) && (load_rd != 5'd0) &&
                   ((use_rs1 && (in_instr[19:15] == load_rd)) ||
                    (use_rs2 && (in_instr[24:20] == load_rd))) && in_valid;

  assign in_ready = !flush && (state_q == ST_RUN) && !hazard && (!out_valid_q || out_ready);
  assign capture  = in_valid && in_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = 3'd0;
    end else if (state_q == ST_RUN) begin
      if (out_valid_q && out_ready && hazard && (LOAD_BUBBLES > 1)) begin
        state_d = ST_BUBBLE;
        cnt_d   = 3'(LOAD_BUBBLES - 1);
      end
    end else begin
      if (cnt_q == 3'd1) begin
        state_d = ST_RUN;
        cnt_d   = 3'd0;
      end else begin
        cnt_d = cnt_q - 3'd1;
      end
    end
  end

  always_comb begin
    out_valid_d   = out_valid_q;
    out_instr_d   = out_instr_q;
    out_pc_d      = out_pc_q;
    out_imm_d     = out_imm_q;
    out_type_d    = out_type_q;
    out_illegal_d = out_illegal_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d   = 1'b1;
      out_instr_d   = in_instr;
      out_pc_d      = in_pc;
      out_imm_d     = imm_in;
      out_type_d    = ins_type_sel;
      out_illegal_d = illegal;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_RUN;
      cnt_q         <= 3'd0;
      out_valid_q   <= 1'b0;
      out_instr_q   <= 32'd0;
      out_pc_q      <= 32'd0;
      out_imm_q     <= 32'd0;
      out_type_q    <= ILLEGAL_SEL;
      out_illegal_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_instr_q   <= out_instr_d;
      out_pc_q      <= out_pc_d;
      out_imm_q     <= out_imm_d;
      out_type_q    <= out_type_d;
      out_illegal_q <= out_illegal_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_instr   = out_instr_q;
  assign out_pc      = out_pc_q;
  assign out_imm     = out_imm_q;
  assign out_type    = out_type_q;
  assign out_illegal = out_illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_imm_decode_ctrl.sv
// tb_imm_decode_ctrl: directed bench for imm_decode_ctrl with LOAD_BUBBLES=1 and =3 instances.
`default_nettype none

module tb_imm_decode_ctrl;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] imm_in;
  logic        flush;
  logic        out_ready;

  logic        a_in_ready, a_out_valid, a_out_illegal;
  logic [2:0]  a_sel, a_out_type;
  logic [31:0] a_out_instr, a_out_pc, a_out_imm;
  logic        b_in_ready, b_out_valid, b_out_illegal;
  logic [2:0]  b_sel, b_out_type;
  logic [31:0] b_out_instr, b_out_pc, b_out_imm;

  int n_checks = 0;
  int n_pass   = 0;

  imm_decode_ctrl #(.LOAD_BUBBLES(1), .ILLEGAL_SEL(3'b111)) u_lb1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .ins_type_sel(a_sel), .imm_in(imm_in),
    .flush(flush), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_instr(a_out_instr), .out_pc(a_out_pc), .out_imm(a_out_imm),
    .out_type(a_out_type), .out_illegal(a_out_illegal)
  );

  imm_decode_ctrl #(.LOAD_BUBBLES(3), .ILLEGAL_SEL(3'b111)) u_lb3 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .ins_type_sel(b_sel), .imm_in(imm_in),
    .flush(flush), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_instr(b_out_instr), .out_pc(b_out_pc), .out_imm(b_out_imm),
    .out_type(b_out_type), .out_illegal(b_out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the sign extender that sits next to the block.
  function automatic logic [31:0] sext(input logic [31:0] i, input logic [2:0] sel);
    case (sel)
      3'd0:    sext = {{20{i[31]}}, i[31:20]};
      3'd1:    sext = {{20{i[31]}}, i[31:25], i[11:7]};
      3'd2:    sext = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'd3:    sext = {i[31:12], 12'd0};
      3'd4:    sext = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: sext = 32'd0;
    endcase
  endfunction

  always_comb imm_in = sext(in_instr, a_sel);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    in_instr  = 32'h0000_0013;
    in_pc     = 32'd0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  localparam logic [31:0] I_ADDI  = 32'hFFF0_0093;
  localparam logic [31:0] I_LW5   = 32'h0001_2283;
  localparam logic [31:0] I_LW0   = 32'h0001_2003;
  localparam logic [31:0] I_ADD5  = 32'h0012_8333;
  localparam logic [31:0] I_ADD0  = 32'h0010_0333;
  localparam logic [31:0] I_JAL   = 32'h0080_006F;
  localparam logic [31:0] I_BAD   = 32'h0000_007F;
  localparam logic [31:0] I_FENCE = 32'h0000_000F;

  initial begin
    // Reset with random inputs applied.
    rst_n     = 1'b0;
    in_valid  = 1'($urandom);
    flush     = 1'($urandom);
    out_ready = 1'($urandom);
    in_instr  = $urandom;
    in_pc     = $urandom;
    #12;
    check("rst_out_valid", {31'd0, a_out_valid}, 32'd0);
    check("rst_out_type", {29'd0, a_out_type}, 32'd7);
    check("rst_out_illegal", {31'd0, a_out_illegal}, 32'd0);
    check("rst_out_imm", a_out_imm, 32'd0);
    check("rst_out_instr", a_out_instr, 32'd0);
    do_reset();
    check("rst_in_ready", {31'd0, a_in_ready}, 32'd1);

    // ADDI x1,x0,-1
    in_instr = I_ADDI; in_pc = 32'h0000_0100; in_valid = 1'b1;
    @(negedge clk);
    check("addi_sel", {29'd0, a_sel}, 32'd0);
    step();
    in_valid = 1'b0;
    check("addi_valid", {31'd0, a_out_valid}, 32'd1);
    check("addi_imm", a_out_imm, 32'hFFFF_FFFF);
    check("addi_pc", a_out_pc, 32'h0000_0100);
    check("addi_type", {29'd0, a_out_type}, 32'd0);
    step();
    check("addi_drain", {31'd0, a_out_valid}, 32'd0);

    // Load-use with LOAD_BUBBLES=1: out_valid 1,0,1
    do_reset();
    in_instr = I_LW5; in_pc = 32'h200; in_valid = 1'b1;
    step();
    check("lu_v0", {31'd0, a_out_valid}, 32'd1);
    in_instr = I_ADD5; in_pc = 32'h204;
    @(negedge clk);
    check("lu_hold_ready", {31'd0, a_in_ready}, 32'd0);
    step();
    check("lu_v1", {31'd0, a_out_valid}, 32'd0);
    step();
    in_valid = 1'b0;
    check("lu_v2", {31'd0, a_out_valid}, 32'd1);
    check("lu_instr", a_out_instr, I_ADD5);

    // LW x0 never hazards: out_valid 1,1
    do_reset();
    in_instr = I_LW0; in_pc = 32'h300; in_valid = 1'b1;
    step();
    check("x0_v0", {31'd0, a_out_valid}, 32'd1);
    in_instr = I_ADD0; in_pc = 32'h304;
    @(negedge clk);
    check("x0_ready", {31'd0, a_in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("x0_v1", {31'd0, a_out_valid}, 32'd1);
    check("x0_instr", a_out_instr, I_ADD0);

    // Backpressure holding JAL
    do_reset();
    out_ready = 1'b0;
    in_instr = I_JAL; in_pc = 32'h400; in_valid = 1'b1;
    step();
    in_instr = I_ADDI; in_pc = 32'h404;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("bp_ready", {31'd0, a_in_ready}, 32'd0);
      check("bp_valid", {31'd0, a_out_valid}, 32'd1);
      check("bp_imm", a_out_imm, 32'h0000_0008);
      check("bp_instr", a_out_instr, I_JAL);
      check("bp_type", {29'd0, a_out_type}, 32'd4);
      step();
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release", {31'd0, a_in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("bp_next", a_out_instr, I_ADDI);

    // LOAD_BUBBLES=3: three empty cycles between load and consumer
    do_reset();
    in_instr = I_LW5; in_valid = 1'b1;
    step();
    check("lb3_load", {31'd0, b_out_valid}, 32'd1);
    in_instr = I_ADD5;
    for (int k = 0; k < 3; k++) begin
      step();
      check("lb3_bubble", {31'd0, b_out_valid}, 32'd0);
    end
    step();
    in_valid = 1'b0;
    check("lb3_consumer", {31'd0, b_out_valid}, 32'd1);
    check("lb3_instr", b_out_instr, I_ADD5);

    // Flush during BUBBLE
    do_reset();
    in_instr = I_LW5; in_valid = 1'b1;
    step();
    in_instr = I_ADD5;
    step();
    @(negedge clk);
    check("fl_bubble_ready", {31'd0, b_in_ready}, 32'd0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("fl_valid", {31'd0, b_out_valid}, 32'd0);
    @(negedge clk);
    check("fl_resume_ready", {31'd0, b_in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    check("fl_capture", {31'd0, b_out_valid}, 32'd1);
    check("fl_instr", b_out_instr, I_ADD5);

    // Illegal opcode
    do_reset();
    in_instr = I_BAD; in_pc = 32'h500; in_valid = 1'b1;
    @(negedge clk);
    check("ill_sel", {29'd0, a_sel}, 32'd7);
    step();
    in_valid = 1'b0;
    check("ill_flag", {31'd0, a_out_illegal}, 32'd1);
    check("ill_type", {29'd0, a_out_type}, 32'd7);
    check("ill_imm", a_out_imm, 32'd0);

    // FENCE depends on the optional decode
    in_instr = I_FENCE; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
`ifdef IMM_SYS_DECODE_EN
    check("fence_illegal", {31'd0, a_out_illegal}, 32'd0);
    check("fence_type", {29'd0, a_out_type}, 32'd0);
`else
    check("fence_illegal", {31'd0, a_out_illegal}, 32'd1);
    check("fence_type", {29'd0, a_out_type}, 32'd7);
`endif

    // Reset mid-operation drops the held instruction
    out_ready = 1'b0;
    in_instr = I_ADDI; in_valid = 1'b1;
    step();
    check("mid_valid_pre", {31'd0, a_out_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", {31'd0, a_out_valid}, 32'd0);
    rst_n = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imm_decode_ctrl.md
Name: imm_decode_ctrl

Overview:
- Decode-stage sequencer that drives the immediate sign-extension unit and owns the ID/EX immediate register.
- Classifies each fetched instruction's opcode into an immediate-type select and feeds it to the sign extender instance beside it. Registers the extended immediate with the instruction and PC.
- Uses a valid/ready handshake on both sides and inserts load-use bubbles.
- Handles flush.

Parameters:
- LOAD_BUBBLES, 1, number of empty output cycles forced after a hazarding load departs. Legal range 1..7.
- ILLEGAL_SEL, 3'b111, type-select value driven for R-type and illegal opcodes. The sign extender returns 0 for this value.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  IF/ID holds an instruction
- in_ready  output  1  block accepts in_instr/in_pc this cycle
- in_instr  input  32  fetched instruction
- in_pc  input  32  PC of in_instr
- ins_type_sel  output  3  combinational type select to the sign extender; 0=I, 1=S, 2=B, 3=U, 4=J
- imm_in  input  32  extended immediate returned by the sign extender for in_instr
- flush  input  1  synchronous kill from branch resolution
- out_valid  output  1  ID/EX register holds a valid instruction
- out_ready  input  1  EX accepts the output this cycle
- out_instr  output  32  registered instruction
- out_pc  output  32  registered PC
- out_imm  output  32  registered immediate
- out_type  output  3  registered ins_type_sel
- out_illegal  output  1  registered illegal-opcode flag

Behaviour:
- Reset (async, rst_n=0) values:
  - out_valid=0; out_instr, out_pc and out_imm = 0.
  - out_type=ILLEGAL_SEL; out_illegal=0.
  - state=RUN; bubble counter=0.
- ins_type_sel decode, combinational from in_instr[6:0]:
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111 -> 0.
  - STORE 0100011 -> 1.
  - BRANCH 1100011 -> 2.
  - LUI 0110111, AUIPC 0010111 -> 3.
  - JAL 1101111 -> 4.
  - OP 0110011 -> ILLEGAL_SEL, not illegal.
  - Anything else -> ILLEGAL_SEL, illegal=1.
- Source usage for hazard detection:
  - rs1 = in_instr[19:15] is used by I-type (excluding LUI/AUIPC/JAL), S, B and R.
  - rs2 = in_instr[24:20] is used by S, B and R.
- hazard = out_valid & out_instr[6:0]==LOAD & rd(out_instr[11:7])!=0 & rd matches a used source of in_instr & in_valid.
- in_ready = !flush & state==RUN & !hazard & (!out_valid | out_ready).
- Capture (in_valid & in_ready):
  - Next cycle out_valid=1; out_instr, out_pc, out_imm, out_type and out_illegal take the current-cycle values.
  - Latency is exactly one cycle.
- If out_valid & out_ready & no capture, out_valid->0. If out_valid & !out_ready, all out_* registers hold unchanged.
- State machine:
  - RUN: a hazarding load departs (out_valid & out_ready & hazard). If LOAD_BUBBLES=1, stay in RUN. Otherwise go to BUBBLE with cnt=LOAD_BUBBLES-1.
  - BUBBLE: in_ready=0. cnt decrements each cycle; at cnt==1 go to RUN.
  - Result: exactly LOAD_BUBBLES cycles with out_valid=0 between the load and its consumer, given continuous in_valid and out_ready.
- A rd=x0 load never triggers a hazard.
- flush has priority over everything:
  - Next cycle out_valid=0.
  - state->RUN, cnt->0.
  - No capture in the flush cycle (in_ready=0).
  - out_* data registers may hold stale values.
- Reset mid-operation drops any held instruction and bubble in progress.

Optional Feature:
- Macro: IMM_SYS_DECODE_EN.
- Defined: FENCE 0001111 and SYSTEM 1110011 decode as ins_type_sel=0, illegal=0. They use rs1 for hazard purposes.
- Undefined: both opcodes are illegal with ILLEGAL_SEL.

Test Plan:
- Reset: rst_n=0 with random inputs -> out_valid=0, out_type=3'b111, out_illegal=0, in_ready=1 after release.
- ADDI x1,x0,-1 (0xFFF00093) with in_valid=1, out_ready=1:
  - ins_type_sel=0 combinationally.
  - Next cycle out_valid=1, out_imm=0xFFFFFFFF, out_pc=in_pc.
- LW x5,0(x2) followed by ADD x6,x5,x1, LOAD_BUBBLES=1, out_ready=1:
  - ADD is held one cycle with in_ready=0.
  - out_valid sequence is 1,0,1.
- Same pair with LW x0 -> no bubble, out_valid sequence 1,1.
- Backpressure: out_ready=0 for 3 cycles with JAL (0x0080006F) held -> out_* stable, in_ready=0, out_imm=0x00000008.
- Flush during BUBBLE (LOAD_BUBBLES=3), and illegal opcode 0x0000007F:
  - Flush: next cycle out_valid=0, state RUN, capture resumes the following cycle.
  - Illegal opcode: out_illegal=1, out_type=3'b111, out_imm=0.
